// File: rtl/chip8_framebuffer.sv
// chip8_framebuffer: 32x64 CHIP-8 display buffer with sprite XOR-draw engine and video read port
module chip8_framebuffer #(
    parameter bit WRAP = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [7:0]  cmd_x,
    input  logic [7:0]  cmd_y,
    input  logic [3:0]  cmd_n,
    output logic        spr_rd,
    output logic [3:0]  spr_idx,
    input  logic [7:0]  spr_data,
    output logic        done,
    output logic        vf_out,
    input  logic [4:0]  vid_addr,
    output logic [63:0] vid_data
);
    typedef enum logic [2:0] {IDLE, CLS, FETCH, WAIT, WRITE, FIN} state_t;
    state_t state, state_nx;
    logic [63:0]  rows [32];
    logic [5:0]   x_q;
    logic [4:0]   y_q;
    logic [3:0]   n_q;
    logic         op_q;
    logic [4:0]   r_q;
    logic [7:0]   byte_q;
    logic         acc;
    logic [127:0] ext;
    logic [63:0]  mask;
    logic [5:0]   ty;
    logic         skip;
    logic         last_row;
    logic         accept;
    logic         unused_ok;
    assign unused_ok = ^{cmd_x[7:6], cmd_y[7:5]};
    // sprite mask and target row; columns past 63 land in ext[63:0] and fold back only when wrapping
    always_comb begin
        ext      = {byte_q, 120'b0} >> x_q;
        mask     = WRAP ? (ext[127:64] | ext[63:0]) : ext[127:64];
        ty       = {1'b0, y_q} + {1'b0, r_q};
        skip     = !WRAP && ty[5];
        last_row = (r_q + 5'd1) == {1'b0, n_q};
        accept   = cmd_valid && (state == IDLE);
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = !accept ? IDLE : cmd_op ? CLS : (cmd_n == 4'd0) ? FIN : FETCH;
            CLS:     state_nx = (r_q == 5'd31) ? FIN : CLS;
            FETCH:   state_nx = WAIT;
            WAIT:    state_nx = WRITE;
            WRITE:   state_nx = last_row ? FIN : FETCH;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state-decoded outputs
    always_comb begin
        cmd_ready = state == IDLE;
        spr_rd    = state == FETCH;
        spr_idx   = r_q[3:0];
        done      = state == FIN;
    end
    // buffer, command latches and video read; the read sees the row value from before any same-edge write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rows[i] <= '0;
            vid_data <= '0;
            vf_out   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            n_q      <= '0;
            op_q     <= 1'b0;
            r_q      <= '0;
            byte_q   <= '0;
            acc      <= 1'b0;
        end else begin
            vid_data <= rows[vid_addr];
            if (accept) begin
                x_q  <= cmd_x[5:0];
                y_q  <= cmd_y[4:0];
                n_q  <= cmd_n;
                op_q <= cmd_op;
                r_q  <= '0;
                acc  <= 1'b0;
            end
            if (state == CLS) begin
                rows[r_q] <= '0;
                r_q       <= r_q + 5'd1;
            end
            if (state == WAIT) byte_q <= spr_data;
            if (state == WRITE) begin
                if (!skip) begin
                    rows[ty[4:0]] <= rows[ty[4:0]] ^ mask;
                    acc           <= acc | (|(rows[ty[4:0]] & mask));
                end
                r_q <= r_q + 5'd1;
            end
            if (state == FIN && !op_q) vf_out <= acc;
        end
    end
endmodule

// File: tb/tb_chip8_framebuffer.sv
// tb_chip8_framebuffer: directed checks of clipping and wrapping framebuffers driven in lockstep
module tb_chip8_framebuffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_op = 1'b0;
    logic [7:0]  cmd_x = '0;
    logic [7:0]  cmd_y = '0;
    logic [3:0]  cmd_n = '0;
    logic [7:0]  spr_data = '0;
    logic [4:0]  vid_addr = '0;
    logic        cmd_ready0, cmd_ready1, spr_rd0, spr_rd1, done0, done1, vf0, vf1;
    logic [3:0]  spr_idx0, spr_idx1;
    logic [63:0] vd0, vd1;
    logic [7:0]  mem [16];
    int          tests = 0;
    int          fails = 0;

    chip8_framebuffer #(.WRAP(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .spr_rd(spr_rd0), .spr_idx(spr_idx0),
        .spr_data(spr_data), .done(done0), .vf_out(vf0), .vid_addr(vid_addr), .vid_data(vd0)
    );
    chip8_framebuffer #(.WRAP(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .spr_rd(spr_rd1), .spr_idx(spr_idx1),
        .spr_data(spr_data), .done(done1), .vf_out(vf1), .vid_addr(vid_addr), .vid_data(vd1)
    );

    always #5 clk = ~clk;

    // sprite memory answers one cycle after the strobe; junk otherwise
    always @(posedge clk) spr_data <= spr_rd0 ? mem[spr_idx0] : 8'hA5;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [63:0] d0, output logic [63:0] d1);
        @(negedge clk);
        vid_addr = a;
        @(posedge clk);
        @(negedge clk);
        d0 = vd0;
        d1 = vd1;
    endtask

    task automatic row_chk(input string tag, input logic [4:0] a, input logic [63:0] e0, input logic [63:0] e1);
        logic [63:0] d0, d1;
        rd(a, d0, d1);
        chk({tag, "_w0"}, d0, e0);
        chk({tag, "_w1"}, d1, e1);
    endtask

    task automatic issue(input logic op, input logic [7:0] x, input logic [7:0] y, input logic [3:0] n);
        @(negedge clk);
        chk("ready_before_issue", cmd_ready0 & cmd_ready1, 1'b1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_x = x;
        cmd_y = y;
        cmd_n = n;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_op = 1'b0;
    endtask

    task automatic drw(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                       input int exp_lat, input logic exp_vf0, input logic exp_vf1);
        int lat;
        issue(1'b0, x, y, n);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done0 && lat < 200);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_done1"}, done1, 1'b1);
        @(negedge clk);
        chk({tag, "_vf0"}, vf0, exp_vf0);
        chk({tag, "_vf1"}, vf1, exp_vf1);
    endtask

    task automatic cls(input logic exp_vf);
        int lat, busy;
        issue(1'b1, 8'd0, 8'd0, 4'd1);
        lat = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!cmd_ready0) busy++;
            cmd_valid = (lat == 5 || lat == 20);
        end while (!done0 && lat < 200);
        cmd_valid = 1'b0;
        chk("cls_lat", lat, 33);
        chk("cls_busy", busy, 33);
        @(negedge clk);
        chk("cls_vf0", vf0, exp_vf);
        chk("cls_vf1", vf1, exp_vf);
        for (int i = 0; i < 32; i++) row_chk("cls_row", 5'(i), 64'h0, 64'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", {cmd_ready0, cmd_ready1}, 2'b11);
        chk("rst_vf", {vf0, vf1}, 2'b00);
        chk("rst_done", {done0, done1}, 2'b00);
        chk("rst_sprrd", {spr_rd0, spr_rd1}, 2'b00);
        for (int i = 0; i < 32; i++) row_chk("rst_row", 5'(i), 64'h0, 64'h0);

        mem[0] = 8'hF0;
        drw("drw_f0", 8'd0, 8'd0, 4'd1, 4, 1'b0, 1'b0);
        row_chk("row0_f0", 5'd0, 64'hF000_0000_0000_0000, 64'hF000_0000_0000_0000);
        drw("drw_f0_again", 8'd0, 8'd0, 4'd1, 4, 1'b1, 1'b1);
        row_chk("row0_erased", 5'd0, 64'h0, 64'h0);
        mem[0] = 8'h81;
        drw("drw_81", 8'd8, 8'd0, 4'd1, 4, 1'b0, 1'b0);
        row_chk("row0_81", 5'd0, 64'h0081_0000_0000_0000, 64'h0081_0000_0000_0000);

        mem[0] = 8'hFF;
        mem[1] = 8'h3C;
        drw("drw_two", 8'd0, 8'd3, 4'd2, 7, 1'b0, 1'b0);
        row_chk("row3", 5'd3, 64'hFF00_0000_0000_0000, 64'hFF00_0000_0000_0000);
        row_chk("row4", 5'd4, 64'h3C00_0000_0000_0000, 64'h3C00_0000_0000_0000);
        mem[0] = 8'h81;
        drw("drw_81_erase", 8'd8, 8'd0, 4'd1, 4, 1'b1, 1'b1);
        row_chk("row0_cleared", 5'd0, 64'h0, 64'h0);
        cls(1'b1);

        mem[0] = 8'hFF;
        mem[1] = 8'hFF;
        mem[2] = 8'hFF;
        drw("drw_edge", 8'd60, 8'd30, 4'd3, 10, 1'b0, 1'b0);
        row_chk("edge_row30", 5'd30, 64'h0000_0000_0000_000F, 64'hF000_0000_0000_000F);
        row_chk("edge_row31", 5'd31, 64'h0000_0000_0000_000F, 64'hF000_0000_0000_000F);
        row_chk("edge_row0", 5'd0, 64'h0, 64'hF000_0000_0000_000F);
        row_chk("edge_row1", 5'd1, 64'h0, 64'h0);
        cls(1'b0);
        drw("drw_edge_big", 8'd124, 8'd62, 4'd3, 10, 1'b0, 1'b0);
        row_chk("big_row30", 5'd30, 64'h0000_0000_0000_000F, 64'hF000_0000_0000_000F);
        row_chk("big_row31", 5'd31, 64'h0000_0000_0000_000F, 64'hF000_0000_0000_000F);
        row_chk("big_row0", 5'd0, 64'h0, 64'hF000_0000_0000_000F);
        cls(1'b0);

        mem[0] = 8'hF0;
        drw("drw_pre_rst", 8'd0, 8'd0, 4'd1, 4, 1'b0, 1'b0);
        row_chk("pre_rst_row0", 5'd0, 64'hF000_0000_0000_0000, 64'hF000_0000_0000_0000);
        issue(1'b0, 8'd0, 8'd0, 4'd2);
        @(negedge clk);
        chk("midrst_fetch", {spr_rd0, spr_rd1}, 2'b11);
        @(negedge clk);
        chk("midrst_wait", {spr_rd0, cmd_ready0}, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("midrst_vid0", vd0, 64'h0);
        chk("midrst_vid1", vd1, 64'h0);
        chk("midrst_ready", {cmd_ready0, cmd_ready1}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_quiet", {done0, done1, spr_rd0, spr_rd1}, 4'b0000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_nodone", {done0, done1}, 2'b00);
        end
        row_chk("postrst_row0", 5'd0, 64'h0, 64'h0);

        drw("drw_f0_x0", 8'd0, 8'd0, 4'd1, 4, 1'b0, 1'b0);
        drw("drw_f0_x2", 8'd2, 8'd0, 4'd1, 4, 1'b1, 1'b1);
        row_chk("row0_cc", 5'd0, 64'hCC00_0000_0000_0000, 64'hCC00_0000_0000_0000);
        drw("drw_n0", 8'd5, 8'd5, 4'd0, 1, 1'b0, 1'b0);
        row_chk("n0_row0", 5'd0, 64'hCC00_0000_0000_0000, 64'hCC00_0000_0000_0000);
        row_chk("n0_row5", 5'd5, 64'h0, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
